// File: rtl/cpu_pkg.sv
// Shared CPU types: field widths and the reservation-station entry record.
package cpu_pkg;
  localparam int OPCODE_W = 7;
  localparam int FUNC3_W  = 3;
  localparam int ROB_W    = 4;
  localparam int DATA_W   = 32;
  localparam int PC_W     = 32;

  typedef struct packed {
    logic                busy;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                func1;
    logic                q1_pend;
    logic [ROB_W-1:0]    q1_tag;
    logic [DATA_W-1:0]   v1;
    logic                q2_pend;
    logic [ROB_W-1:0]    q2_tag;
    logic [DATA_W-1:0]   v2;
    logic [DATA_W-1:0]   imm;
    logic [PC_W-1:0]     pc;
    logic [ROB_W-1:0]    rob;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station: tracks allocation order and picks
// the single oldest ready entry.
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [DEPTH-1:0]         busy,
  input  logic [DEPTH-1:0]         ready,
  output logic                     sel_valid,
  output logic [DEPTH-1:0]         sel_onehot,
  output logic [$clog2(DEPTH)-1:0] sel_idx
);
  localparam int IDX_W = $clog2(DEPTH);

  // older[j][i] = 1 means entry j was allocated before entry i
  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blocked;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (alloc) begin
      for (int j = 0; j < DEPTH; j++) older[j][alloc_idx] <= busy[j];
      older[alloc_idx] <= '0;
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && older[j][i]) blocked[i] = 1'b1;
  end

  assign sel_onehot = ready & ~blocked;
  assign sel_valid  = |sel_onehot;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
  end
endmodule

// File: rtl/rs_ooo_sel.sv
// Reservation station: buffers ALU ops until operands arrive over NUM_CDB
// broadcast buses and issues the oldest ready entry over valid/ready.
module rs_ooo_sel #(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int ROB_W   = cpu_pkg::ROB_W,
  parameter int DATA_W  = cpu_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      disp_valid,
  input  logic [ROB_W-1:0]          disp_rob,
  input  logic [6:0]                disp_opcode,
  input  logic [2:0]                disp_func3,
  input  logic                      disp_func1,
  input  logic                      disp_q1_pend,
  input  logic [ROB_W-1:0]          disp_q1_tag,
  input  logic [DATA_W-1:0]         disp_v1,
  input  logic                      disp_q2_pend,
  input  logic [ROB_W-1:0]          disp_q2_tag,
  input  logic [DATA_W-1:0]         disp_v2,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [31:0]               disp_pc,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_val,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [6:0]                iss_opcode,
  output logic [2:0]                iss_func3,
  output logic                      iss_func1,
  output logic [DATA_W-1:0]         iss_v1,
  output logic [DATA_W-1:0]         iss_v2,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [31:0]               iss_pc,
  output logic [ROB_W-1:0]          iss_rob
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  cpu_pkg::rs_entry_t ent [DEPTH];
  cpu_pkg::rs_entry_t disp_ent;

  logic [DEPTH-1:0] busy, ready, sel_onehot;
  logic             sel_valid, free_found;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic             alloc, iss_load, iss_take;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]  = ent[i].busy;
      ready[i] = ent[i].busy && !ent[i].q1_pend && !ent[i].q2_pend;
    end
  end

  // Lowest-index free slot, from registered busy only
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
  end

  assign full     = (count == CNT_W'(DEPTH));
  assign alloc    = rdy && disp_valid && !full && free_found && !flush && !rst;
  assign iss_load = rdy && (!iss_valid || iss_ready);
  assign iss_take = iss_load && sel_valid;

  // Descending channel scan so the lowest channel wins on duplicate tags;
  // conditions use the dispatched pend bits so a capture cannot mask another.
  always_comb begin
    disp_ent         = '0;
    disp_ent.busy    = 1'b1;
    disp_ent.opcode  = disp_opcode;
    disp_ent.func3   = disp_func3;
    disp_ent.func1   = disp_func1;
    disp_ent.q1_pend = disp_q1_pend;
    disp_ent.q1_tag  = disp_q1_tag;
    disp_ent.v1      = disp_v1;
    disp_ent.q2_pend = disp_q2_pend;
    disp_ent.q2_tag  = disp_q2_tag;
    disp_ent.v2      = disp_v2;
    disp_ent.imm     = disp_imm;
    disp_ent.pc      = disp_pc;
    disp_ent.rob     = disp_rob;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (disp_q1_pend && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == disp_q1_tag) begin
        disp_ent.q1_pend = 1'b0;
        disp_ent.v1      = cdb_val[k*DATA_W +: DATA_W];
      end
      if (disp_q2_pend && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == disp_q2_tag) begin
        disp_ent.q2_pend = 1'b0;
        disp_ent.v2      = cdb_val[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
          if (ent[i].busy && ent[i].q1_pend && cdb_valid[k] &&
              cdb_tag[k*ROB_W +: ROB_W] == ent[i].q1_tag) begin
            ent[i].q1_pend <= 1'b0;
            ent[i].v1      <= cdb_val[k*DATA_W +: DATA_W];
          end
          if (ent[i].busy && ent[i].q2_pend && cdb_valid[k] &&
              cdb_tag[k*ROB_W +: ROB_W] == ent[i].q2_tag) begin
            ent[i].q2_pend <= 1'b0;
            ent[i].v2      <= cdb_val[k*DATA_W +: DATA_W];
          end
        end
        if (iss_take && sel_onehot[i]) ent[i].busy <= 1'b0;
      end
      if (alloc) ent[free_idx] <= disp_ent;
    end
  end

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .alloc      (alloc),
    .alloc_idx  (free_idx),
    .busy       (busy),
    .ready      (ready),
    .sel_valid  (sel_valid),
    .sel_onehot (sel_onehot),
    .sel_idx    (sel_idx)
  );

  // Issue stage boundary: selected entry moves into the output register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      iss_valid  <= 1'b0;
      iss_opcode <= '0;
      iss_func3  <= '0;
      iss_func1  <= 1'b0;
      iss_v1     <= '0;
      iss_v2     <= '0;
      iss_imm    <= '0;
      iss_pc     <= '0;
      iss_rob    <= '0;
    end else if (iss_load) begin
      iss_valid <= sel_valid;
      if (sel_valid) begin
        iss_opcode <= ent[sel_idx].opcode;
        iss_func3  <= ent[sel_idx].func3;
        iss_func1  <= ent[sel_idx].func1;
        iss_v1     <= ent[sel_idx].v1;
        iss_v2     <= ent[sel_idx].v2;
        iss_imm    <= ent[sel_idx].imm;
        iss_pc     <= ent[sel_idx].pc;
        iss_rob    <= ent[sel_idx].rob;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count <= '0;
    else if (rdy)     count <= count + CNT_W'(alloc) - CNT_W'(iss_take);
  end

`ifndef SYNTHESIS
  a_no_disp_when_full: assert property (@(posedge clk) disable iff (rst)
    !(rdy && disp_valid && full && !flush));
`endif
endmodule

// File: tb/tb_rs_ooo_sel.sv
// Directed bench for rs_ooo_sel: vector table for single-op cases plus
// sequences for timing, ordering, back-pressure, freeze and flush.
module tb_rs_ooo_sel;
  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        full;
  logic [4:0]  count;
  logic        disp_valid;
  logic [3:0]  disp_rob;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_func3;
  logic        disp_func1;
  logic        disp_q1_pend;
  logic [3:0]  disp_q1_tag;
  logic [31:0] disp_v1;
  logic        disp_q2_pend;
  logic [3:0]  disp_q2_tag;
  logic [31:0] disp_v2;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic        iss_valid, iss_ready;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_func3;
  logic        iss_func1;
  logic [31:0] iss_v1, iss_v2, iss_imm, iss_pc;
  logic [3:0]  iss_rob;

  int n_chk = 0;
  int n_fail = 0;

  rs_ooo_sel #(.DEPTH(16), .NUM_CDB(2), .ROB_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .full(full), .count(count),
    .disp_valid(disp_valid), .disp_rob(disp_rob), .disp_opcode(disp_opcode),
    .disp_func3(disp_func3), .disp_func1(disp_func1),
    .disp_q1_pend(disp_q1_pend), .disp_q1_tag(disp_q1_tag), .disp_v1(disp_v1),
    .disp_q2_pend(disp_q2_pend), .disp_q2_tag(disp_q2_tag), .disp_v2(disp_v2),
    .disp_imm(disp_imm), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_func3(iss_func3), .iss_func1(iss_func1), .iss_v1(iss_v1), .iss_v2(iss_v2),
    .iss_imm(iss_imm), .iss_pc(iss_pc), .iss_rob(iss_rob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        q1p; logic [3:0] q1t; logic [31:0] v1;
    logic        q2p; logic [3:0] q2t; logic [31:0] v2;
    logic [1:0]  cv;
    logic [3:0]  t0; logic [31:0] c0;
    logic [3:0]  t1; logic [31:0] c1;
    logic [3:0]  rob; logic [2:0] f3; logic f1; logic [31:0] imm;
    logic [31:0] ev1; logic [31:0] ev2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    disp_valid = 0; disp_rob = 0; disp_opcode = 0; disp_func3 = 0; disp_func1 = 0;
    disp_q1_pend = 0; disp_q1_tag = 0; disp_v1 = 0;
    disp_q2_pend = 0; disp_q2_tag = 0; disp_v2 = 0; disp_imm = 0; disp_pc = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
  endtask

  task automatic disp_ready(input logic [3:0] rob, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] pc);
    disp_valid = 1; disp_rob = rob; disp_opcode = 7'h33; disp_func3 = 3'd0; disp_func1 = 0;
    disp_q1_pend = 0; disp_q1_tag = 0; disp_v1 = v1;
    disp_q2_pend = 0; disp_q2_tag = 0; disp_v2 = v2; disp_imm = 0; disp_pc = pc;
  endtask

  task automatic disp_pend1(input logic [3:0] rob, input logic [3:0] tag, input logic [31:0] pc);
    disp_ready(rob, 32'd0, 32'h10, pc);
    disp_q1_pend = 1; disp_q1_tag = tag;
  endtask

  initial begin
    rst = 1; rdy = 1; flush = 0; iss_ready = 1;
    clear_in();
    tick(); tick();
    rst = 0;
    tick();
    chk("reset_count", count, 0);
    chk("reset_iss_valid", iss_valid, 0);
    chk("reset_full", full, 0);
    chk("reset_iss_v1", iss_v1, 0);

    //   q1p q1t   v1     q2p q2t   v2    cv     t0     c0       t1     c1      rob   f3    f1  imm     ev1      ev2
    vecs[0] = '{0, 4'd0, 32'd5, 0, 4'd0, 32'd7, 2'b00, 4'd0, 32'h0,   4'd0, 32'h0,   4'd3, 3'd0, 0, 32'h0,  32'd5,   32'd7};
    vecs[1] = '{0, 4'd0, 32'd1, 1, 4'd9, 32'd0, 2'b01, 4'd9, 32'hAA,  4'd0, 32'h0,   4'd2, 3'd4, 1, 32'h14, 32'd1,   32'hAA};
    vecs[2] = '{1, 4'd6, 32'd0, 0, 4'd0, 32'd3, 2'b10, 4'd0, 32'h0,   4'd6, 32'h55,  4'd1, 3'd7, 0, 32'hFF, 32'h55,  32'd3};
    vecs[3] = '{1, 4'd2, 32'd0, 1, 4'd5, 32'd0, 2'b11, 4'd5, 32'h500, 4'd2, 32'h200, 4'd7, 3'd1, 1, 32'h8,  32'h200, 32'h500};
    vecs[4] = '{1, 4'd7, 32'd0, 0, 4'd0, 32'd9, 2'b11, 4'd7, 32'h111, 4'd7, 32'h222, 4'd8, 3'd2, 0, 32'h0,  32'h111, 32'd9};
    vecs[5] = '{0, 4'd4, 32'h1234, 0, 4'd0, 32'd2, 2'b01, 4'd4, 32'hDEAD, 4'd0, 32'h0, 4'd9, 3'd5, 1, 32'h3, 32'h1234, 32'd2};

    for (int v = 0; v < 6; v++) begin
      disp_valid = 1; disp_rob = vecs[v].rob; disp_opcode = 7'h33;
      disp_func3 = vecs[v].f3; disp_func1 = vecs[v].f1;
      disp_q1_pend = vecs[v].q1p; disp_q1_tag = vecs[v].q1t; disp_v1 = vecs[v].v1;
      disp_q2_pend = vecs[v].q2p; disp_q2_tag = vecs[v].q2t; disp_v2 = vecs[v].v2;
      disp_imm = vecs[v].imm; disp_pc = 32'h100 + v;
      cdb_valid = vecs[v].cv;
      cdb_tag = {vecs[v].t1, vecs[v].t0};
      cdb_val = {vecs[v].c1, vecs[v].c0};
      iss_ready = 1;
      tick();
      clear_in();
      chk($sformatf("v%0d_count_after_disp", v), count, 1);
      chk($sformatf("v%0d_not_yet_valid", v), iss_valid, 0);
      tick();
      chk($sformatf("v%0d_iss_valid", v), iss_valid, 1);
      chk($sformatf("v%0d_iss_v1", v), iss_v1, vecs[v].ev1);
      chk($sformatf("v%0d_iss_v2", v), iss_v2, vecs[v].ev2);
      chk($sformatf("v%0d_iss_rob", v), iss_rob, vecs[v].rob);
      chk($sformatf("v%0d_iss_f3f1", v), {iss_func3, iss_func1}, {vecs[v].f3, vecs[v].f1});
      chk($sformatf("v%0d_iss_imm_pc", v), {iss_imm, iss_pc}, {vecs[v].imm, 32'h100 + v});
      chk($sformatf("v%0d_count_after_issue", v), count, 0);
      tick();
      chk($sformatf("v%0d_accepted", v), iss_valid, 0);
    end

    // Wakeup two cycles after dispatch; an unrelated tag must not wake it
    disp_pend1(4'd1, 4'd6, 32'h200);
    tick();
    clear_in();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd5}; cdb_val = {32'h0, 32'h99};
    tick();
    clear_in();
    chk("wake_wait1", iss_valid, 0);
    cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_val = {32'h55, 32'h0};
    tick();
    clear_in();
    chk("wake_wait2", iss_valid, 0);
    tick();
    chk("wake_iss_valid", iss_valid, 1);
    chk("wake_iss_v1", iss_v1, 32'h55);
    chk("wake_iss_rob", iss_rob, 1);

    // rdy=0 freezes: ALU ready and a dispatch are both ignored
    rdy = 0;
    disp_ready(4'd2, 32'd1, 32'd1, 32'h300);
    tick(); tick();
    chk("freeze_iss_valid", iss_valid, 1);
    chk("freeze_iss_rob", iss_rob, 1);
    chk("freeze_count", count, 0);
    clear_in();
    rdy = 1;
    tick();
    chk("unfreeze_drained", iss_valid, 0);
    chk("unfreeze_count", count, 0);

    // Three waiters on one tag issue in dispatch order
    for (int k = 0; k < 3; k++) begin
      disp_pend1(4'(4 + k), 4'd2, 32'h400 + k);
      tick();
    end
    clear_in();
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_val = {32'h0, 32'h77};
    tick();
    clear_in();
    chk("multi_count", count, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("multi_valid%0d", k), iss_valid, 1);
      chk($sformatf("multi_rob%0d", k), iss_rob, 4 + k);
      chk($sformatf("multi_v1_%0d", k), iss_v1, 32'h77);
    end
    tick();
    chk("multi_done", iss_valid, 0);

    // Fill to full under back-pressure; slot 0 is reused so age differs from index
    iss_ready = 0;
    for (int k = 0; k < 17; k++) begin
      disp_ready(4'(k), k, 100 + k, 32'h1000 + k);
      tick();
    end
    clear_in();
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d_valid", c), iss_valid, 1);
      chk($sformatf("stall%0d_pc", c), iss_pc, 32'h1000);
      chk($sformatf("stall%0d_v2", c), iss_v2, 100);
    end
    iss_ready = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("drain%0d_pc", k), iss_pc, 32'h1000 + k);
      chk($sformatf("drain%0d_count", k), count, 16 - k);
    end
    chk("drain_full_clear", full, 0);
    tick();
    chk("drain_done", iss_valid, 0);

    // Flush with 8 busy, a held issue and a simultaneous dispatch
    iss_ready = 0;
    for (int k = 0; k < 9; k++) begin
      disp_ready(4'(k), k, k, 32'h2000 + k);
      tick();
    end
    clear_in();
    chk("preflush_count", count, 8);
    chk("preflush_valid", iss_valid, 1);
    flush = 1;
    iss_ready = 1;
    disp_ready(4'd15, 32'd3, 32'd3, 32'h3000);
    tick();
    flush = 0;
    clear_in();
    chk("flush_count", count, 0);
    chk("flush_valid", iss_valid, 0);
    chk("flush_pc", iss_pc, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("postflush%0d_valid", c), iss_valid, 0);
    end
    chk("postflush_count", count, 0);
    disp_ready(4'd11, 32'd21, 32'd22, 32'h4000);
    tick();
    clear_in();
    tick();
    chk("recover_valid", iss_valid, 1);
    chk("recover_pc", iss_pc, 32'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
